dda_uart_streamer: RTL

//   Downstream of the Van der Pol DDA core. Decimates the x/y state stream,

---
 rtl/dda_uart_streamer_if.sv | 32 +++
 rtl/dda_uart_streamer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dda_uart_streamer_if.sv
// Stream-side bundle for dda_uart_streamer.
//   master : the producer/observer side (DDA core + host capture), drives en/sample_valid/x/y
//   slave  : the streamer itself, drives tx/busy/frame_done/overrun_cnt
// Signals:
//   en, sample_valid  stream enable and 1-cycle new-sample strobe
//   x, y              DDA state words (posit, N bits)
//   tx                UART serial out, idle high
//   busy              frame in progress
//   frame_done        1-cycle pulse after the final stop bit
//   overrun_cnt       saturating count of triggers dropped while busy
interface dda_uart_streamer_if #(
  parameter int unsigned N = 16
);
  logic         en;
  logic         sample_valid;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         tx;
  logic         busy;
  logic         frame_done;
  logic [7:0]   overrun_cnt;

  modport master (
    output en, sample_valid, x, y,
    input  tx, busy, frame_done, overrun_cnt
  );

  modport slave (
    input  en, sample_valid, x, y,
    output tx, busy, frame_done, overrun_cnt
  );
endinterface

// File: rtl/dda_uart_streamer.sv
// Decimates the DDA x/y sample stream and ships one (x,y) snapshot per DECIM accepted
// samples as a back-to-back 8N1 UART frame: x[15:8], x[7:0], y[15:8], y[7:0].
// Optional macro STREAM_CHECKSUM_EN appends a 5th byte, the XOR of the four payload bytes.
// Ports:
//   clk      clock
//   rst_n    asynchronous reset, active low (aborts any frame, tx forced high)
//   io_strm  slave modport of dda_uart_streamer_if (en/sample_valid/x/y in,
//            tx/busy/frame_done/overrun_cnt out)
module dda_uart_streamer #(
  parameter int unsigned N         = 16,
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DECIM     = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  dda_uart_streamer_if.slave  io_strm
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef STREAM_CHECKSUM_EN
  localparam logic [2:0] LastByte = 3'd4;
`else
  localparam logic [2:0] LastByte = 3'd3;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e         r_state, w_state_nxt;
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic [2:0]     r_bit, w_bit_nxt;
  logic [2:0]     r_byte, w_byte_nxt;
  logic [2*N-1:0] r_shadow, w_shadow_nxt;
  logic [DW-1:0]  r_dec, w_dec_nxt;
  logic [7:0]     r_ovr, w_ovr_nxt;
  logic           r_tx, w_tx_nxt;

  logic           w_trigger;
  logic           w_busy;
  logic           w_bit_end;
  logic [7:0]     w_byte_val;

  assign w_trigger = io_strm.en && io_strm.sample_valid && (r_dec == DW'(DECIM - 1));
  assign w_busy    = (r_state == StStart) || (r_state == StData) || (r_state == StStop);
  assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_shadow <= '0;
      r_dec    <= '0;
      r_ovr    <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bit    <= w_bit_nxt;
      r_byte   <= w_byte_nxt;
      r_shadow <= w_shadow_nxt;
      r_dec    <= w_dec_nxt;
      r_ovr    <= w_ovr_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bit_nxt    = r_bit;
    w_byte_nxt   = r_byte;
    w_shadow_nxt = r_shadow;
    w_dec_nxt    = r_dec;
    w_ovr_nxt    = r_ovr;
    w_byte_val   = 8'h00;
    w_tx_nxt     = 1'b1;

    // Decimation counter: cleared while disabled, wraps on every trigger.
    if (!io_strm.en) begin
      w_dec_nxt = '0;
    end else if (io_strm.sample_valid) begin
      w_dec_nxt = w_trigger ? '0 : r_dec + DW'(1);
    end

    if (w_trigger && w_busy && (r_ovr != 8'hFF)) begin
      w_ovr_nxt = r_ovr + 8'd1;
    end

    unique case (r_state)
      StIdle, StDone: begin
        w_state_nxt = StIdle;
        if (w_trigger) begin
          w_state_nxt  = StStart;
          w_timer_nxt  = '0;
          w_bit_nxt    = '0;
          w_byte_nxt   = '0;
          w_shadow_nxt = {io_strm.x, io_strm.y};
        end
      end
      StStart: begin
        w_timer_nxt = r_timer + TW'(1);
        if (w_bit_end) begin
          w_timer_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StData;
        end
      end
      StData: begin
        w_timer_nxt = r_timer + TW'(1);
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      StStop: begin
        w_timer_nxt = r_timer + TW'(1);
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_byte == LastByte) begin
            w_state_nxt = StDone;
          end else begin
            w_byte_nxt  = r_byte + 3'd1;
            w_state_nxt = StStart;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // tx is registered from next-state values so the pin is glitch-free and the start bit
    // appears on the trigger edge itself.
    case (w_byte_nxt)
      3'd0:    w_byte_val = w_shadow_nxt[2*N-1 -: 8];
      3'd1:    w_byte_val = w_shadow_nxt[2*N-9 -: 8];
      3'd2:    w_byte_val = w_shadow_nxt[N-1 -: 8];
      3'd3:    w_byte_val = w_shadow_nxt[N-9 -: 8];
`ifdef STREAM_CHECKSUM_EN
      3'd4:    w_byte_val = w_shadow_nxt[2*N-1 -: 8] ^ w_shadow_nxt[2*N-9 -: 8]
                          ^ w_shadow_nxt[N-1 -: 8]   ^ w_shadow_nxt[N-9 -: 8];
`endif
      default: w_byte_val = 8'h00;
    endcase

    unique case (w_state_nxt)
      StStart: w_tx_nxt = 1'b0;
      StData:  w_tx_nxt = w_byte_val[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign io_strm.tx          = r_tx;
  assign io_strm.busy        = w_busy;
  assign io_strm.frame_done  = (r_state == StDone);
  assign io_strm.overrun_cnt = r_ovr;

endmodule
